// File: rtl/ntt_pointwise_loader_if.sv
// Handshake and INTT load-port bundle between the pointwise loader and its neighbours.
// The slave modport is the loader; the master modport is the operand source / INTT side.
interface ntt_pointwise_loader_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic                  intt_go;
  logic                  intt_load_coeff;
  logic [ADDR_WIDTH-1:0] intt_load_addr;
  logic [WIDTH-1:0]      intt_load_data;
  logic                  intt_start;
  logic                  intt_done;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output in_valid, in_a, in_b, intt_go, intt_done,
    input  in_ready, intt_load_coeff, intt_load_addr, intt_load_data,
           intt_start, busy, frame_done
  );

  modport slave (
    input  in_valid, in_a, in_b, intt_go, intt_done,
    output in_ready, intt_load_coeff, intt_load_addr, intt_load_data,
           intt_start, busy, frame_done
  );
endinterface

// File: rtl/ntt_pointwise_loader.sv
// Pointwise (a*b) mod Q feeder for the inverse NTT: loads N products, starts the INTT, waits for done.
// Define PWM_AUTO_START_EN to start the INTT straight after the drain instead of waiting for intt_go.
//
// state   | meaning
// S_LOAD  | accepting coefficient pairs
// S_DRAIN | flushing the 2-stage multiply/reduce pipeline
// S_ARM   | all products loaded, waiting for intt_go
// S_START | one-cycle intt_start pulse
// S_WAIT  | INTT running, waiting for intt_done
// S_DONE  | one-cycle frame_done pulse
module ntt_pointwise_loader #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int Q          = 8380417,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_pointwise_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOAD, S_DRAIN, S_ARM, S_START, S_WAIT, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]  N_CNT = (ADDR_WIDTH+1)'(N);
  localparam logic [2*WIDTH-1:0]   Q_W   = (2*WIDTH)'(Q);

  state_t                state;
  logic [ADDR_WIDTH:0]   acc_cnt;
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [ADDR_WIDTH:0]   wr_cnt_nxt;
  logic                  ready_int;
  logic                  accept;
  logic                  load_strobe;

  logic                  s1_valid;
  logic [2*WIDTH-1:0]    s1_prod;
  logic [ADDR_WIDTH-1:0] s1_idx;
  logic                  s2_valid;
  logic [WIDTH-1:0]      s2_res;
  logic [ADDR_WIDTH-1:0] s2_idx;
  logic [WIDTH-1:0]      res_mod;

  assign ready_int  = (state == S_LOAD) && (acc_cnt < N_CNT);
  assign accept     = bus.in_valid && ready_int && !rst;
  assign wr_cnt_nxt = wr_cnt + {{ADDR_WIDTH{1'b0}}, s2_valid};
  assign res_mod    = WIDTH'(s1_prod % Q_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (accept)   acc_cnt <= acc_cnt + 1'b1;
      if (s2_valid) wr_cnt  <= wr_cnt_nxt;
      case (state)
        S_LOAD:  if (accept && (acc_cnt == N_CNT - 1'b1)) state <= S_DRAIN;
        // Leave on the cycle the last product is written so the drain is exactly two cycles.
        S_DRAIN: if (wr_cnt_nxt == N_CNT) begin
`ifdef PWM_AUTO_START_EN
          state <= S_START;
`else
          state <= S_ARM;
`endif
        end
        S_ARM:   if (bus.intt_go) state <= S_START;
        S_START: state <= S_WAIT;
        S_WAIT:  if (bus.intt_done) state <= S_DONE;
        S_DONE: begin
          state   <= S_LOAD;
          acc_cnt <= '0;
          wr_cnt  <= '0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod <= (2*WIDTH)'(bus.in_a) * (2*WIDTH)'(bus.in_b);
        s1_idx  <= acc_cnt[ADDR_WIDTH-1:0];
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= res_mod;
        s2_idx <= s1_idx;
      end
    end
  end

`ifdef PWM_AUTO_START_EN
  logic unused_go;
  assign unused_go = bus.intt_go;
`endif

  // Strobes are masked in the reset cycle itself, not only after it.
  assign load_strobe         = s2_valid && !rst;
  assign bus.in_ready        = ready_int && !rst;
  assign bus.intt_load_coeff = load_strobe;
  assign bus.intt_load_addr  = load_strobe ? s2_idx : '0;
  assign bus.intt_load_data  = load_strobe ? s2_res : '0;
  assign bus.intt_start      = (state == S_START) && !rst;
  assign bus.frame_done      = (state == S_DONE) && !rst;
  assign bus.busy            = !rst && !((state == S_LOAD) && (acc_cnt == '0));

endmodule

// File: tb/tb_ntt_pointwise_loader.sv
// Bench for ntt_pointwise_loader: directed frame sequence with random operands, checked
// against a queue of (address, (a*b) mod Q, due cycle) built from the accepted pairs.
module tb_ntt_pointwise_loader;
  localparam int N          = 256;
  localparam int WIDTH      = 32;
  localparam int Q          = 8380417;
  localparam int ADDR_WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_pointwise_loader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ntt_pointwise_loader #(
    .N(N), .WIDTH(WIDTH), .Q(Q), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int              addr;
    longint unsigned data;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int ncyc = 0, acc_idx = 0, frame_loads = 0, n_starts = 0, n_done = 0;
  longint unsigned pa, pb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Reference model: every accepted pair k must appear as a load at address k, two cycles later.
  always @(negedge clk) begin
    if (rst) begin
      check("strobe_in_reset", {61'd0, bus.intt_load_coeff, bus.intt_start, bus.frame_done}, 64'd0);
      exp_q.delete();
      acc_idx     = 0;
      frame_loads = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        pa = bus.in_a;
        pb = bus.in_b;
        exp_q.push_back('{acc_idx, (pa * pb) % longint'(Q), ncyc + 2});
        acc_idx++;
      end
      if (bus.intt_load_coeff) begin
        check("load_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("load_addr", bus.intt_load_addr, e.addr);
          check("load_data", bus.intt_load_data, e.data);
          check("load_cycle", ncyc, e.due);
        end
        frame_loads++;
      end else if (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
        check("missed_load", bus.intt_load_coeff, 1);
        void'(exp_q.pop_front());
      end
      if (bus.intt_start) begin
        n_starts++;
        check("loads_before_start", frame_loads, N);
      end
      if (bus.frame_done) begin
        n_done++;
        acc_idx     = 0;
        frame_loads = 0;
      end
    end
    ncyc++;
  end

  // pattern: 0 a=i,b=1 / 1 (Q-1,Q-1) / 2 (4194304,2) / other random
  task automatic send(input int pattern, input bit gaps, input int count);
    int sent = 0;
    bit tog  = 1'b1;
    for (int c = 0; c < 4 * N && sent < count; c++) begin
      bus.in_valid = gaps ? tog : 1'b1;
      tog = !tog;
      case (pattern)
        0:       begin bus.in_a = WIDTH'(sent);  bus.in_b = 1; end
        1:       begin bus.in_a = WIDTH'(Q - 1); bus.in_b = WIDTH'(Q - 1); end
        2:       begin bus.in_a = 32'd4194304;   bus.in_b = 32'd2; end
        default: begin bus.in_a = $urandom;      bus.in_b = $urandom; end
      endcase
      check("ready_in_load", bus.in_ready, 1);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("accepted_pairs", sent, count);
  endtask

  // Entered in the first drain cycle; returns in LOAD of the next frame.
  task automatic finish_frame(input bit go_early, input int idle_arm, input int done_delay);
    if (go_early) bus.intt_go = 1'b1;
    mid();
    check("ready_drain", bus.in_ready, 0);
    check("busy_drain", bus.busy, 1);
    tick();
    tick();
    for (int i = 0; i < idle_arm; i++) begin
      mid();
      check("no_start_without_go", bus.intt_start, 0);
      check("busy_arm", bus.busy, 1);
      tick();
    end
    bus.intt_go = 1'b1;
    mid();
    check("no_start_in_arm", bus.intt_start, 0);
    tick();
    bus.intt_go = 1'b0;
    mid();
    check("start_pulse", bus.intt_start, 1);
    tick();
    mid();
    check("start_one_cycle", bus.intt_start, 0);
    for (int i = 0; i < done_delay; i++) tick();
    mid();
    check("no_done_in_wait", bus.frame_done, 0);
    check("busy_wait", bus.busy, 1);
    bus.intt_done = 1'b1;
    tick();
    bus.intt_done = 1'b0;
    mid();
    check("frame_done_pulse", bus.frame_done, 1);
    check("ready_in_done", bus.in_ready, 0);
    tick();
    mid();
    check("frame_done_one_cycle", bus.frame_done, 0);
    check("ready_after_done", bus.in_ready, 1);
    check("idle_not_busy", bus.busy, 0);
    tick();
  endtask

  int starts0, done0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.intt_go   = 1'b0;
    bus.intt_done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    mid();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_load_addr", bus.intt_load_addr, 0);
    check("rst_load_data", bus.intt_load_data, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    mid();
    check("ready_after_rst", bus.in_ready, 1);
    check("busy_after_rst", bus.busy, 0);
    tick();

    send(0, 1'b0, N);
    finish_frame(1'b0, 10, 4096);

    bus.intt_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("done_ignored_in_load", bus.frame_done, 0);
      tick();
    end
    bus.intt_done = 1'b0;
    send(1, 1'b0, N);
    finish_frame(1'b1, 0, 5);

    send(2, 1'b1, N);
    finish_frame(1'b0, 3, 7);

    send(3, 1'b1, N);
    finish_frame(1'b1, 0, $urandom_range(1, 30));

    send(3, 1'b0, 100);
    rst = 1'b1;
    mid();
    check("ready_in_reset", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    starts0 = n_starts;
    mid();
    check("busy_after_abort", bus.busy, 0);
    tick();
    send(3, 1'b0, N);
    finish_frame(1'b1, 0, 3);
    check("one_start_after_abort", n_starts, starts0 + 1);

    send(3, 1'b0, N);
    bus.intt_go = 1'b1;
    tick();
    tick();
    tick();
    bus.intt_go = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done0 = n_done;
    bus.intt_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.intt_done = 1'b0;
    mid();
    check("no_done_after_wait_abort", n_done, done0);
    check("idle_after_wait_abort", bus.busy, 0);
    check("frame_done_count", n_done, 5);
    check("start_count", n_starts, 6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_pointwise_loader.md
# ntt_pointwise_loader

Upstream feeder for the inverse NTT pipeline.
- Accepts a stream of N coefficient pairs (a_i, b_i) in the NTT domain and multiplies each pair modulo Q through a 2-stage pipeline.
- Writes the products into the inverse NTT's load port at addresses 0..N-1, pulses its start, waits for its done, and signals frame completion.
- Sits between the forward-transformed operand sources and the inverse NTT; together they form the polynomial-multiply datapath.

## Interface
Parameters:
- N, 256, frame length (coefficients per polynomial)
- WIDTH, 32, coefficient width
- Q, 8380417, modulus
- ADDR_WIDTH, 8, log2(N)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input pair valid
- in_ready  output  1  block accepts a pair this cycle
- in_a  input  WIDTH  operand a_i
- in_b  input  WIDTH  operand b_i
- intt_go  input  1  release INTT start (used only when the macro is absent)
- intt_load_coeff  output  1  load strobe to INTT
- intt_load_addr  output  ADDR_WIDTH  load address
- intt_load_data  output  WIDTH  load data
- intt_start  output  1  one-cycle start pulse to INTT
- intt_done  input  1  INTT completion level
- busy  output  1  high in every state except LOAD with zero pairs accepted
- frame_done  output  1  one-cycle pulse when the INTT result is ready to read

## Operation
States:
- LOAD: accept pairs. Leave to DRAIN when the N-th pair is accepted.
- DRAIN: flush the pipeline. Leave when the write counter reaches N.
- ARM: wait for intt_go.
- START: assert intt_start for one cycle, then go to WAIT.
- WAIT: wait for intt_done.
- DONE: pulse frame_done for one cycle, then go to LOAD.

Handshake and counters:
- in_ready = (state==LOAD) && (acc_cnt < N).
- A pair is transferred on in_valid && in_ready. Each transfer increments acc_cnt, which is ADDR_WIDTH+1 bits wide.

Pipeline:
- Stage 1: register p = in_a*in_b at full 2*WIDTH width, plus valid bit and index = acc_cnt.
- Stage 2: register r = p mod Q (WIDTH bits), plus valid bit and index.
- When stage 2 is valid, intt_load_coeff=1, intt_load_addr=index[ADDR_WIDTH-1:0], intt_load_data=r. The write counter then increments.
- r equals (a*b) mod Q for any input values, including inputs ≥ Q.

Addressing and INTT control:
- Addresses are natural order. Pair k goes to address k; there is no bit-reversal in this block.
- Loads are issued only in LOAD and DRAIN, so they always precede intt_start. This is required because the INTT accepts loads only while it is idle.
- intt_done is ignored outside WAIT.

Reset:
- In any cycle with rst=1, the block goes to LOAD, clears both counters and both pipeline valids, and suppresses all strobes.
- A reset during WAIT abandons the frame. A later intt_done is ignored because the block is no longer in WAIT.

## Timing
Reset values:
- in_ready=0 during the reset cycle, then 1 starting the first cycle after reset.
- intt_load_coeff=0, intt_load_addr=0, intt_load_data=0, intt_start=0, busy=0, frame_done=0.

Latency and strobes:
- A pair accepted at edge t produces intt_load_coeff high in the cycle after edge t+2. Input-to-load latency is 2 cycles.
- Input bubbles propagate as gaps in intt_load_coeff. Addresses stay contiguous by index.
- Minimum DRAIN is 2 cycles after the last accept.
- intt_start is exactly one cycle wide. It returns low before intt_done can rise, so the INTT leaves its done state on the next cycle.
- frame_done is asserted in the cycle after intt_done is sampled high in WAIT.
- in_ready returns high in the cycle after frame_done.

Throughput and boundaries:
- Best-case frame overhead: N accept cycles + 2 drain + 1 start + INTT runtime + 1 done.
- in_valid held high while in_ready=0 has no effect. The next frame's pairs wait.
- There is no wrap-around. acc_cnt saturates at N until the block returns to LOAD.

## Configuration
- Macro PWM_AUTO_START_EN.
- Defined: DRAIN goes directly to START, and intt_go is ignored.
- Undefined: DRAIN goes to ARM. ARM moves to START on the first cycle intt_go=1; intt_go held high before ARM counts, so START follows DRAIN by one cycle.

## Test plan
- Basic frame: a_i=i, b_i=1, in_valid always high → intt_load_data=i at addr i for i=0..255. Loads occur in cycles 2..257 after the first accept. One intt_start pulse follows.
- Wrap of product: every pair (Q-1, Q-1) → all 256 load_data=1. Pairs (4194304, 2) → 8388608 mod Q = 8191.
- Backpressure: in_valid toggles 1,0,1,0 → loads gapped but addresses 0..255 contiguous. Exactly 256 load strobes, then one start.
- Completion: drive intt_done high 4096 cycles after start → frame_done pulses in the next cycle, and in_ready=1 in the cycle after that. An intt_done asserted during LOAD → no frame_done.
- Reset mid-load: assert rst after 100 accepts → no strobes in the reset cycle. The next frame starts at addr 0, and no intt_start is emitted for the aborted frame.
- Macro off: hold intt_go=0 for 10 cycles after DRAIN → intt_start stays 0 with busy=1. Pulse intt_go → intt_start in the next cycle.
